// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage and the execute stage.
//   - RV32I/M/Zicsr opcode, funct3 and funct7 constants
//   - alu_op encoding (alu_op_e) and div_op encoding
//   - dec_ctrl_t decoded-control bundle and its packed width DEC_CTRL_W
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_PRIV = 3'd0;
  localparam logic [2:0] F3_CSRX = 3'd4;   // reserved slot in the SYSTEM funct3 space

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // div_op carries funct3 of the M-extension divide group
  localparam logic [2:0] DIV_DIV  = 3'b100;
  localparam logic [2:0] DIV_DIVU = 3'b101;
  localparam logic [2:0] DIV_REM  = 3'b110;
  localparam logic [2:0] DIV_REMU = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_ADDI   = 5'd10,
    ALU_SLTI   = 5'd11,
    ALU_SLTIU  = 5'd12,
    ALU_XORI   = 5'd13,
    ALU_ORI    = 5'd14,
    ALU_ANDI   = 5'd15,
    ALU_SRAI   = 5'd16,
    ALU_SLLI   = 5'd17,
    ALU_SRLI   = 5'd18,
    ALU_MUL    = 5'd19,
    ALU_MULH   = 5'd20,
    ALU_MULHSU = 5'd21,
    ALU_MULHU  = 5'd22
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        is_branch;
    logic [2:0]  b_type;
    logic        jal;
    logic        jalr;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_type;
    logic        is_div;
    logic [2:0]  div_op;
    logic        is_lui;
    logic        is_auipc;
    logic [2:0]  csr_func;
    logic        halt;
    logic        illegal;
  } dec_ctrl_t;

  localparam int DEC_CTRL_W = $bits(dec_ctrl_t);

endpackage

// File: rtl/decode_logic.sv
// decode_logic: combinational RV32I(+M, +Zicsr) instruction decoder.
//   i_instr : raw 32-bit instruction
//   o_ctrl  : decoded control bundle; any illegal encoding yields an
//             all-zero bundle with only illegal=1
// ENABLE_M / ENABLE_CSR turn the corresponding extensions into illegal
// encodings when 0.
module decode_logic
  import decode_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0] i_instr,
  output dec_ctrl_t   o_ctrl
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_shamt;
  dec_ctrl_t   w_ctrl;
  logic        w_legal;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_rd     = i_instr[11:7];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_j  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_shamt  = {27'b0, i_instr[24:20]};

  always_comb begin
    w_ctrl  = '0;
    w_legal = 1'b1;
    case (w_opcode)
      OP_LUI: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.imm       = w_imm_u;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.is_lui    = 1'b1;
      end
      OP_AUIPC: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.imm       = w_imm_u;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.is_auipc  = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.imm       = w_imm_j;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jal       = 1'b1;
      end
      OP_JALR: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.rs1       = w_rs1;
        w_ctrl.imm       = w_imm_i;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jalr      = 1'b1;
        if (w_f3 != 3'd0) w_legal = 1'b0;
      end
      OP_BRANCH: begin
        w_ctrl.rs1       = w_rs1;
        w_ctrl.rs2       = w_rs2;
        w_ctrl.imm       = w_imm_b;
        w_ctrl.alu_op    = ALU_SUB;
        w_ctrl.is_branch = 1'b1;
        w_ctrl.b_type    = w_f3;
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_legal = 1'b0;
      end
      OP_LOAD: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.rs1       = w_rs1;
        w_ctrl.imm       = w_imm_i;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.is_load   = 1'b1;
        w_ctrl.mem_type  = w_f3;
        if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_legal = 1'b0;
      end
      OP_STORE: begin
        w_ctrl.rs1      = w_rs1;
        w_ctrl.rs2      = w_rs2;
        w_ctrl.imm      = w_imm_s;
        w_ctrl.alu_src  = 1'b1;
        w_ctrl.is_store = 1'b1;
        w_ctrl.mem_type = w_f3;
        if (w_f3 > 3'd2) w_legal = 1'b0;
      end
      OP_IMM: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.rs1       = w_rs1;
        w_ctrl.imm       = w_imm_i;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (w_f3)
          F3_ADD:  w_ctrl.alu_op = ALU_ADDI;
          F3_SLT:  w_ctrl.alu_op = ALU_SLTI;
          F3_SLTU: w_ctrl.alu_op = ALU_SLTIU;
          F3_XOR:  w_ctrl.alu_op = ALU_XORI;
          F3_OR:   w_ctrl.alu_op = ALU_ORI;
          F3_AND:  w_ctrl.alu_op = ALU_ANDI;
          F3_SLL: begin
            w_ctrl.imm    = w_shamt;
            w_ctrl.alu_op = ALU_SLLI;
            if (w_f7 != F7_BASE) w_legal = 1'b0;
          end
          default: begin
            w_ctrl.imm = w_shamt;
            if (w_f7 == F7_BASE)     w_ctrl.alu_op = ALU_SRLI;
            else if (w_f7 == F7_ALT) w_ctrl.alu_op = ALU_SRAI;
            else                     w_legal = 1'b0;
          end
        endcase
      end
      OP_REG: begin
        w_ctrl.rd        = w_rd;
        w_ctrl.rs1       = w_rs1;
        w_ctrl.rs2       = w_rs2;
        w_ctrl.reg_write = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_ADD:  w_ctrl.alu_op = ALU_ADD;
            F3_SLL:  w_ctrl.alu_op = ALU_SLL;
            F3_SLT:  w_ctrl.alu_op = ALU_SLT;
            F3_SLTU: w_ctrl.alu_op = ALU_SLTU;
            F3_XOR:  w_ctrl.alu_op = ALU_XOR;
            F3_SR:   w_ctrl.alu_op = ALU_SRL;
            F3_OR:   w_ctrl.alu_op = ALU_OR;
            default: w_ctrl.alu_op = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == F3_ADD)     w_ctrl.alu_op = ALU_SUB;
          else if (w_f3 == F3_SR) w_ctrl.alu_op = ALU_SRA;
          else                    w_legal = 1'b0;
        end else if (w_f7 == F7_MULDIV && ENABLE_M) begin
          // funct3[2] splits the multiply group from the divide group
          if (w_f3[2]) begin
            w_ctrl.is_div = 1'b1;
            w_ctrl.div_op = w_f3;
          end else begin
            case (w_f3[1:0])
              2'd0:    w_ctrl.alu_op = ALU_MUL;
              2'd1:    w_ctrl.alu_op = ALU_MULH;
              2'd2:    w_ctrl.alu_op = ALU_MULHSU;
              default: w_ctrl.alu_op = ALU_MULHU;
            endcase
          end
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_FENCE: begin
        // ordering is trivially satisfied by this in-order pipe: legal no-op
        if (w_f3 != 3'd0) w_legal = 1'b0;
      end
      OP_SYSTEM: begin
        if (w_f3 == F3_PRIV) begin
          if (i_instr == INSTR_ECALL || i_instr == INSTR_EBREAK) w_ctrl.halt = 1'b1;
          else                                                    w_legal = 1'b0;
        end else if (w_f3 == F3_CSRX || !ENABLE_CSR) begin
          w_legal = 1'b0;
        end else begin
          w_ctrl.rd        = w_rd;
          w_ctrl.rs1       = w_rs1;
          w_ctrl.reg_write = (w_rd != 5'd0);
          w_ctrl.csr_func  = w_f3;
          // immediate variants carry both the CSR address and the uimm
          if (w_f3[2]) w_ctrl.imm = {i_instr[31:20], 15'b0, i_instr[19:15]};
          else         w_ctrl.imm = {20'b0, i_instr[31:20]};
        end
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
    end
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked decode stage between fetch and execute.
//   clk, rst_n              : clock, async active-low reset
//   flush                   : drop all held entries, clear halt
//   in_valid/in_ready       : fetch handshake (in_ready is a flop)
//   in_pc, in_instr         : fetched instruction and its PC
//   out_valid/out_ready     : execute handshake
//   out_pc, out_ctrl        : registered decoded bundle (dec_ctrl_t)
//   halted                  : an ECALL/EBREAK has been handed to execute
//   decoded_cnt/illegal_cnt : transferred bundles / transferred illegal bundles
//
// state | meaning
// EMPTY | nothing held, out_valid=0, in_ready=1
// ONE   | main register valid, in_ready=1
// TWO   | main and skid registers valid, in_ready=0
module decode_stage
  import decode_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [DEC_CTRL_W-1:0] out_ctrl,
  output logic                  halted,
  output logic [CNT_W-1:0]      decoded_cnt,
  output logic [CNT_W-1:0]      illegal_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [31:0] r_main_pc;
  dec_ctrl_t   r_main_ctrl;
  logic [31:0] r_skid_pc;
  dec_ctrl_t   r_skid_ctrl;
  logic        r_halt_pend;
  logic        r_halted;
  logic [CNT_W-1:0] r_dec_cnt;
  logic [CNT_W-1:0] r_ill_cnt;

  dec_ctrl_t   w_dec;
  logic        w_acc;
  logic        w_xfer;
  logic        w_halt_pend_nxt;

  decode_logic #(
    .ENABLE_M   (ENABLE_M),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_decode_logic (
    .i_instr (in_instr),
    .o_ctrl  (w_dec)
  );

  assign w_acc  = in_valid & r_in_ready;
  assign w_xfer = r_out_valid & out_ready;

  // once a halting instruction is inside, fetch stays blocked until flush
  assign w_halt_pend_nxt = r_halt_pend | (w_acc & w_dec.halt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_acc && !w_xfer)      w_state_nxt = ST_TWO;
        else if (!w_acc && w_xfer) w_state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (w_xfer) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_pc   <= '0;
      r_main_ctrl <= '0;
      r_skid_pc   <= '0;
      r_skid_ctrl <= '0;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      // computed from next state so out_ready never reaches in_ready combinationally
      r_in_ready  <= (w_state_nxt != ST_TWO) && !w_halt_pend_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      if (w_xfer && r_main_ctrl.halt) r_halted <= 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main_pc   <= in_pc;
            r_main_ctrl <= w_dec;
          end
        end
        ST_ONE: begin
          if (w_acc && w_xfer) begin
            r_main_pc   <= in_pc;
            r_main_ctrl <= w_dec;
          end else if (w_acc) begin
            r_skid_pc   <= in_pc;
            r_skid_ctrl <= w_dec;
          end
        end
        ST_TWO: begin
          if (w_xfer) begin
            r_main_pc   <= r_skid_pc;
            r_main_ctrl <= r_skid_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  // event counters survive flush; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_ill_cnt <= '0;
    end else if (w_xfer) begin
      r_dec_cnt <= r_dec_cnt + CNT_W'(1);
      if (r_main_ctrl.illegal) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_main_pc;
  assign out_ctrl    = r_main_ctrl;
  assign halted      = r_halted;
  assign decoded_cnt = r_dec_cnt;
  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;

  logic in_ready, out_valid, halted;
  logic [31:0] out_pc;
  logic [DEC_CTRL_W-1:0] out_ctrl;
  logic [31:0] decoded_cnt, illegal_cnt;

  logic in_ready2, out_valid2, halted2;
  logic [31:0] out_pc2;
  logic [DEC_CTRL_W-1:0] out_ctrl2;
  logic [31:0] decoded_cnt2, illegal_cnt2;

  dec_ctrl_t o_s;
  assign o_s = out_ctrl;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_dec  = 0;
  int exp_ill  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .halted(halted),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b0)) dut_min (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_ctrl(out_ctrl2), .halted(halted2),
    .decoded_cnt(decoded_cnt2), .illegal_cnt(illegal_cnt2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  // Random instruction from a known template; expected bundle follows from
  // what was assembled, not from re-decoding the bits.
  task automatic gen_rand(input bit allow_ill, output logic [31:0] ins, output dec_ctrl_t e);
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [19:0] u20;
    int k;
    r = $urandom; rd = r[4:0]; rs1 = r[9:5]; rs2 = r[14:10]; i12 = r[26:15];
    r = $urandom; u20 = r[19:0];
    b13 = {i12, 1'b0};
    k = allow_ill ? $urandom_range(0, 8) : $urandom_range(0, 7);
    e = '0;
    ins = '0;
    case (k)
      0: begin
        ins = {i12, rs1, 3'b000, rd, 7'h13};
        e.rd = rd; e.rs1 = rs1; e.imm = {{20{i12[11]}}, i12};
        e.alu_op = ALU_ADDI; e.alu_src = 1'b1; e.reg_write = 1'b1;
      end
      1: begin
        ins = {1'b0, r[20], 5'b0, rs2, rs1, 3'b000, rd, 7'h33};
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.reg_write = 1'b1;
        e.alu_op = r[20] ? ALU_SUB : ALU_ADD;
      end
      2: begin
        ins = {i12, rs1, 3'b010, rd, 7'h03};
        e.rd = rd; e.rs1 = rs1; e.imm = {{20{i12[11]}}, i12};
        e.alu_src = 1'b1; e.reg_write = 1'b1; e.is_load = 1'b1; e.mem_type = 3'd2;
      end
      3: begin
        ins = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
        e.rs1 = rs1; e.rs2 = rs2; e.imm = {{20{i12[11]}}, i12};
        e.alu_src = 1'b1; e.is_store = 1'b1; e.mem_type = 3'd2;
      end
      4: begin
        ins = {b13[12], b13[10:5], rs2, rs1, 3'b001, b13[4:1], b13[11], 7'h63};
        e.rs1 = rs1; e.rs2 = rs2; e.imm = {{19{b13[12]}}, b13};
        e.alu_op = ALU_SUB; e.is_branch = 1'b1; e.b_type = 3'd1;
      end
      5: begin
        ins = {u20, rd, 7'h37};
        e.rd = rd; e.imm = {u20, 12'b0}; e.alu_src = 1'b1;
        e.reg_write = 1'b1; e.is_lui = 1'b1;
      end
      6: begin
        ins = {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.alu_op = ALU_MUL; e.reg_write = 1'b1;
      end
      7: begin
        ins = {7'h01, rs2, rs1, 3'b110, rd, 7'h33};
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.is_div = 1'b1;
        e.div_op = 3'b110; e.reg_write = 1'b1;
      end
      default: begin
        ins = {u20, rd, 7'h7F};
        e.illegal = 1'b1;
      end
    endcase
  endtask

  // FIFO reference: occupancy of the queue gives expected valid/ready each cycle.
  task automatic run_stream(input int n, input bit rnd_ready, input bit allow_ill,
                            input logic [31:0] pc0);
    logic [31:0] q_pc[$];
    dec_ctrl_t   q_ctrl[$];
    logic [31:0] ins, pc, r;
    dec_ctrl_t   e;
    bit pending, acc, xfer;
    int sent, got, cyc;
    pc = pc0; ins = '0; e = '0; sent = 0; got = 0; cyc = 0; pending = 0;
    while (got < n && cyc < 2000) begin
      if (sent < n && !pending) begin
        gen_rand(allow_ill, ins, e);
        pending = 1;
      end
      in_valid = pending;
      in_pc    = pc;
      in_instr = ins;
      if (rnd_ready) begin
        r = $urandom;
        out_ready = (r[1:0] != 2'b00);
      end else begin
        out_ready = !(cyc >= 2 && cyc <= 4);
      end
      chk("stream_out_valid", out_valid, q_pc.size() > 0);
      chk("stream_in_ready", in_ready, q_pc.size() < 2);
      xfer = (q_pc.size() > 0) && out_ready;
      acc  = pending && (q_pc.size() < 2);
      if (xfer) begin
        chk("stream_pc", out_pc, q_pc[0]);
        chk("stream_ctrl", out_ctrl, q_ctrl[0]);
        exp_dec++;
        if (q_ctrl[0].illegal) exp_ill++;
        void'(q_pc.pop_front());
        void'(q_ctrl.pop_front());
        got++;
      end
      if (acc) begin
        q_pc.push_back(pc);
        q_ctrl.push_back(e);
        pc += 32'd4;
        sent++;
        pending = 0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_complete", got, n);
    chk("stream_decoded_cnt", decoded_cnt, exp_dec);
    chk("stream_illegal_cnt", illegal_cnt, exp_ill);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_ctrl_t e;
    dec_ctrl_t ill;
    ill = '0;
    ill.illegal = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_decoded_cnt", decoded_cnt, 32'h0);
    chk("rst_illegal_cnt", illegal_cnt, 32'h0);

    // ADDI x1,x0,5
    out_ready = 1'b1;
    send1(32'h100, 32'h0050_0093);
    e = '0; e.rd = 5'd1; e.imm = 32'd5; e.alu_op = ALU_ADDI; e.alu_src = 1'b1; e.reg_write = 1'b1;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_ctrl", out_ctrl, e);
    chk("addi_aluop_code", o_s.alu_op, 5'b01010);
    tick(); exp_dec++;
    chk("addi_drained", out_valid, 1'b0);
    chk("addi_cnt", decoded_cnt, exp_dec);

    // SRAI x5,x6,3 and its illegal funct7 variant
    send1(32'h104, 32'h4033_5293);
    e = '0; e.rd = 5'd5; e.rs1 = 5'd6; e.imm = 32'd3; e.alu_op = ALU_SRAI;
    e.alu_src = 1'b1; e.reg_write = 1'b1;
    chk("srai_ctrl", out_ctrl, e);
    chk("srai_aluop_code", o_s.alu_op, 5'b10000);
    tick(); exp_dec++;
    send1(32'h108, 32'h2033_5293);
    chk("srai_bad_ctrl", out_ctrl, ill);
    chk("srai_bad_regwrite", o_s.reg_write, 1'b0);
    tick(); exp_dec++; exp_ill++;
    chk("srai_bad_illcnt", illegal_cnt, exp_ill);

    // MUL with and without the M extension
    send1(32'h10C, 32'h0220_81B3);
    e = '0; e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.alu_op = ALU_MUL; e.reg_write = 1'b1;
    chk("mul_ctrl", out_ctrl, e);
    chk("mul_aluop_code", o_s.alu_op, 5'b10011);
    chk("mul_disabled", out_ctrl2, ill);
    tick(); exp_dec++;

    // DIVU
    send1(32'h110, 32'h0220_D1B3);
    e = '0; e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.is_div = 1'b1;
    e.div_op = 3'b101; e.reg_write = 1'b1;
    chk("divu_ctrl", out_ctrl, e);
    tick(); exp_dec++;

    // CSRRW x1,0x300,x2
    send1(32'h114, 32'h3001_10F3);
    e = '0; e.rd = 5'd1; e.rs1 = 5'd2; e.imm = 32'h300; e.csr_func = 3'd1; e.reg_write = 1'b1;
    chk("csrrw_ctrl", out_ctrl, e);
    tick(); exp_dec++;

    // CSRRSI x0,0x305,5: rd=0 so no register write
    send1(32'h118, 32'h3052_E073);
    e = '0; e.rs1 = 5'd5; e.imm = 32'h3050_0005; e.csr_func = 3'd6;
    chk("csrrsi_ctrl", out_ctrl, e);
    chk("csr_disabled", out_ctrl2, ill);
    tick(); exp_dec++;
    chk("directed_dec_cnt", decoded_cnt, exp_dec);
    chk("directed_ill_cnt", illegal_cnt, exp_ill);

    // 8-instruction stream with out_ready low in cycles 2-4, then a long random one
    run_stream(8, 1'b0, 1'b0, 32'h1000);
    run_stream(40, 1'b1, 1'b1, 32'h2000);

    // flush while holding two entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h0050_0093;
    tick();
    in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    chk("two_in_ready", in_ready, 1'b0);
    chk("two_out_valid", out_valid, 1'b1);
    chk("two_out_pc", out_pc, 32'h300);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_dec_cnt", decoded_cnt, exp_dec);

    // in_valid during a flush from EMPTY is dropped
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30C;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", out_valid, 1'b0);
    tick();
    chk("flush_drop_valid_later", out_valid, 1'b0);

    // ECALL halts fetch until flush
    out_ready = 1'b0;
    send1(32'h200, 32'h0000_0073);
    e = '0; e.halt = 1'b1;
    chk("ecall_ctrl", out_ctrl, e);
    chk("ecall_in_ready", in_ready, 1'b0);
    chk("ecall_halted_early", halted, 1'b0);
    out_ready = 1'b1;
    tick(); exp_dec++;
    chk("ecall_halted", halted, 1'b1);
    chk("ecall_out_valid", out_valid, 1'b0);
    in_valid = 1'b1; in_pc = 32'h204; in_instr = 32'h0050_0093;
    tick(); tick();
    in_valid = 1'b0;
    chk("halt_blocks_in_ready", in_ready, 1'b0);
    chk("halt_blocks_out_valid", out_valid, 1'b0);
    chk("halt_dec_cnt", decoded_cnt, exp_dec);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("unhalt_in_ready", in_ready, 1'b1);
    chk("unhalt_halted", halted, 1'b0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    send1(32'h400, 32'h0050_0093);
    chk("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_pc", out_pc, 32'h0);
    chk("async_rst_out_ctrl", out_ctrl, '0);
    chk("async_rst_dec_cnt", decoded_cnt, 32'h0);
    chk("async_rst_ill_cnt", illegal_cnt, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
